// File: rtl/cipher_pkg.sv
// Shared constants and state encoding for the modular-add cipher stages.
package cipher_pkg;

  localparam logic [7:0] P         = 8'd227;
  localparam logic [7:0] Q         = 8'd225;
  localparam logic [7:0] NULL_CHAR = 8'h00;

  typedef enum logic [1:0] {
    S_NOKEY,
    S_IDLE,
    S_MSG
  } enc_state_t;

endpackage

// File: rtl/mod_p_add.sv
// Combinational (a + b) mod P for operands already reduced below P.
// A single conditional subtract is enough because a + b < 2P.
module mod_p_add
  import cipher_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);

  logic [8:0] sum;
  logic [8:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = sum - {1'b0, P};
  assign y_o  = (sum >= {1'b0, P}) ? diff[7:0] : sum[7:0];

endmodule

// File: rtl/msg_encrypt_stream.sv
// Streaming encryptor: holds a public key and maps each plaintext
// character M to (M + Pk) mod P through a single registered output slot.
// 0x00 terminates a message and is forwarded unencrypted with ctxt_last.
module msg_encrypt_stream
  import cipher_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       pk_in,
  input  logic             pk_ready,
  input  logic             key_err,
  input  logic [7:0]       ptxt_char,
  input  logic             ptxt_valid,
  output logic             ptxt_ready,
  output logic [7:0]       ctxt_char,
  output logic             ctxt_valid,
  output logic             ctxt_last,
  input  logic             ctxt_ready,
  output logic             msg_done,
  output logic             err_invalid_ptxt,
  output logic [CNT_W-1:0] char_count
);

  enc_state_t       state_q, state_d;
  logic [7:0]       key_q, key_d;
  logic [7:0]       char_q, char_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] enc_char;
  logic       in_acc;
  logic       out_xfer;
  logic       is_term;
  logic       in_range;

  mod_p_add u_add (
    .a_i (ptxt_char),
    .b_i (key_q),
    .y_o (enc_char)
  );

  // The slot can take a new character when it is empty or draining now.
  assign ptxt_ready = (state_q != S_NOKEY) && (!vld_q || ctxt_ready);
  assign in_acc     = ptxt_valid && ptxt_ready;
  assign out_xfer   = vld_q && ctxt_ready;
  assign is_term    = (ptxt_char == NULL_CHAR);
  assign in_range   = (ptxt_char < P);

  // Next state: key handling, message framing, output slot and status.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    char_d  = char_q;
    vld_d   = vld_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (out_xfer) begin
      vld_d = 1'b0;
    end

    unique case (state_q)
      S_NOKEY: begin
        if (pk_ready && !key_err) begin
          key_d   = pk_in;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        // Status of the previous message is kept until the next one starts.
        if (in_acc) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = is_term ? S_IDLE : S_MSG;
        end
        // A key error wins over both key reload and message start.
        if (key_err) begin
          key_d   = '0;
          state_d = S_NOKEY;
        end else if (pk_ready) begin
          key_d = pk_in;
        end
      end
      S_MSG: begin
        if (in_acc && is_term) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_NOKEY;
    endcase

    if (in_acc) begin
      if (is_term) begin
        char_d = NULL_CHAR;
        last_d = 1'b1;
        vld_d  = 1'b1;
      end else if (in_range) begin
        char_d = enc_char;
        last_d = 1'b0;
        vld_d  = 1'b1;
        if (cnt_d != {CNT_W{1'b1}}) begin
          cnt_d = cnt_d + 1'b1;
        end
      end else begin
        // Out-of-range characters are swallowed; the slot is empty or
        // draining this cycle, so no beat remains.
        err_d = 1'b1;
        vld_d = 1'b0;
      end
    end
  end

  // State and output registers; a reset drops any beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NOKEY;
      key_q   <= '0;
      char_q  <= NULL_CHAR;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      char_q  <= char_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ctxt_char        = char_q;
  assign ctxt_valid       = vld_q;
  assign ctxt_last        = last_q;
  assign msg_done         = out_xfer && last_q;
  assign err_invalid_ptxt = err_q;
  assign char_count       = cnt_q;

endmodule

// File: tb/tb_msg_encrypt_stream.sv
// Directed bench for msg_encrypt_stream: a scoreboard queue holds the
// expected output beats, a monitor compares each output handshake.
module tb_msg_encrypt_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pk_in;
  logic       pk_ready;
  logic       key_err;
  logic [7:0] ptxt_char;
  logic       ptxt_valid;
  logic       ptxt_ready;
  logic [7:0] ctxt_char;
  logic       ctxt_valid;
  logic       ctxt_last;
  logic       ctxt_ready;
  logic       msg_done;
  logic       err_invalid_ptxt;
  logic [7:0] char_count;

  int vectors     = 0;
  int miscompares = 0;
  int done_pulses = 0;

  logic [8:0] sb[$];

  msg_encrypt_stream #(.CNT_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pk_in            (pk_in),
    .pk_ready         (pk_ready),
    .key_err          (key_err),
    .ptxt_char        (ptxt_char),
    .ptxt_valid       (ptxt_valid),
    .ptxt_ready       (ptxt_ready),
    .ctxt_char        (ctxt_char),
    .ctxt_valid       (ctxt_valid),
    .ctxt_last        (ctxt_last),
    .ctxt_ready       (ctxt_ready),
    .msg_done         (msg_done),
    .err_invalid_ptxt (err_invalid_ptxt),
    .char_count       (char_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (msg_done) done_pulses++;
      if (msg_done && !(ctxt_valid && ctxt_ready && ctxt_last)) begin
        vectors++;
        miscompares++;
        $display("FAIL msg_done_spurious: got 1, expected 0");
      end
      if (ctxt_valid && ctxt_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got char %0d last %0d, expected none", ctxt_char, ctxt_last);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("beat_char", ctxt_char, e[7:0]);
          chk("beat_last", ctxt_last, e[8]);
          chk("msg_done_on_last", msg_done, e[8]);
        end
      end
    end
  end

  // Present one character and wait (bounded) for its acceptance.
  task automatic send(input logic [7:0] c, input logic [7:0] ec, input logic el, input bit beat);
    int n = 0;
    ptxt_char  = c;
    ptxt_valid = 1'b1;
    @(negedge clk);
    while (!ptxt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ptxt_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got ptxt_ready 0, expected 1 for char %0d", c);
      ptxt_valid = 1'b0;
      return;
    end
    if (beat) sb.push_back({el, ec});
    @(posedge clk);
    #1;
    ptxt_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] k);
    pk_in    = k;
    pk_ready = 1'b1;
    @(posedge clk);
    #1;
    pk_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    pk_in      = 8'd0;
    pk_ready   = 1'b0;
    key_err    = 1'b0;
    ptxt_char  = 8'd0;
    ptxt_valid = 1'b0;
    ctxt_ready = 1'b1;
    cycles(3);

    chk("rst_ptxt_ready", ptxt_ready, 0);
    chk("rst_ctxt_valid", ctxt_valid, 0);
    chk("rst_ctxt_char", ctxt_char, 0);
    chk("rst_char_count", char_count, 0);
    chk("rst_err", err_invalid_ptxt, 0);
    rst_n = 1'b1;
    cycles(2);
    chk("nokey_ptxt_ready", ptxt_ready, 0);

    // Pk = 8 (from Sk = 10)
    load_key(8'd8);
    chk("key_ptxt_ready", ptxt_ready, 1);

    // 'A' then terminator
    send(8'd65, 8'd73, 1'b0, 1'b1);
    send(8'd0, 8'd0, 1'b1, 1'b1);
    cycles(3);
    chk("t1_count", char_count, 1);
    chk("t1_done_pulses", done_pulses, 1);

    // Wrap-around, including C = 0 as data
    send(8'd220, 8'd1, 1'b0, 1'b1);
    send(8'd219, 8'd0, 1'b0, 1'b1);
    send(8'd0, 8'd0, 1'b1, 1'b1);
    cycles(3);
    chk("t2_count", char_count, 2);

    // Out-of-range character is dropped and flagged
    send(8'd10, 8'd18, 1'b0, 1'b1);
    chk("t3_err_before", err_invalid_ptxt, 0);
    send(8'd240, 8'd0, 1'b0, 1'b0);
    chk("t3_err_set", err_invalid_ptxt, 1);
    send(8'd11, 8'd19, 1'b0, 1'b1);
    send(8'd0, 8'd0, 1'b1, 1'b1);
    cycles(3);
    chk("t3_count", char_count, 2);
    chk("t3_err_held", err_invalid_ptxt, 1);
    send(8'd5, 8'd13, 1'b0, 1'b1);
    chk("t3_err_cleared", err_invalid_ptxt, 0);
    chk("t3_count_restart", char_count, 1);
    send(8'd0, 8'd0, 1'b1, 1'b1);
    cycles(3);

    // Backpressure: pending beat held stable, input stalled
    ctxt_ready = 1'b0;
    send(8'd1, 8'd9, 1'b0, 1'b1);
    ptxt_char  = 8'd2;
    ptxt_valid = 1'b1;
    sb.push_back({1'b0, 8'd10});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ptxt_ready", ptxt_ready, 0);
      chk("bp_ctxt_char", ctxt_char, 9);
      chk("bp_ctxt_valid", ctxt_valid, 1);
    end
    @(posedge clk);
    #1;
    ctxt_ready = 1'b1;
    @(posedge clk);
    #1;
    ptxt_valid = 1'b0;
    send(8'd3, 8'd11, 1'b0, 1'b1);
    send(8'd0, 8'd0, 1'b1, 1'b1);
    cycles(3);
    chk("bp_count", char_count, 3);

    // Key change requests are ignored inside a message
    send(8'd20, 8'd28, 1'b0, 1'b1);
    pk_in    = 8'd50;
    pk_ready = 1'b1;
    key_err  = 1'b1;
    send(8'd21, 8'd29, 1'b0, 1'b1);
    send(8'd0, 8'd0, 1'b1, 1'b1);
    cycles(2);
    chk("kerr_nokey_ready", ptxt_ready, 0);
    pk_ready = 1'b0;
    key_err  = 1'b0;
    cycles(2);
    chk("t5_done_pulses", done_pulses, 6);

    // Reset with a beat pending mid-message
    load_key(8'd8);
    send(8'd30, 8'd38, 1'b0, 1'b1);
    cycles(2);
    ctxt_ready = 1'b0;
    send(8'd31, 8'd39, 1'b0, 1'b0);
    chk("pre_rst_valid", ctxt_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ctxt_valid", ctxt_valid, 0);
    chk("arst_ctxt_char", ctxt_char, 0);
    chk("arst_ctxt_last", ctxt_last, 0);
    chk("arst_msg_done", msg_done, 0);
    chk("arst_ptxt_ready", ptxt_ready, 0);
    chk("arst_char_count", char_count, 0);
    chk("arst_err", err_invalid_ptxt, 0);
    cycles(2);
    rst_n      = 1'b1;
    ctxt_ready = 1'b1;
    cycles(3);
    chk("post_rst_nokey", ptxt_ready, 0);
    load_key(8'd8);
    send(8'd100, 8'd108, 1'b0, 1'b1);
    send(8'd0, 8'd0, 1'b1, 1'b1);
    cycles(3);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msg_encrypt_stream.md
# msg_encrypt_stream

Streaming encryption stage directly downstream of `public_key_gen`. Latches the public key when `P_K_ready` asserts and encrypts a NUL-terminated plaintext character stream as C = (M + Pk) mod P. Uses valid/ready handshakes and one registered output slot. Feeds the ciphertext sink (UART/TX or storage).

## Interface
- `CNT_W`, 8, width of the per-message encrypted-character counter.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pk_in`  in  8  public key, from `Public_key`.
- `pk_ready`  in  1  key valid, from `P_K_ready`.
- `key_err`  in  1  from `err_invalid_seckey`; drops the held key between messages.
- `ptxt_char`  in  8  plaintext character; 0x00 is the message terminator.
- `ptxt_valid`  in  1  plaintext valid.
- `ptxt_ready`  out  1  stage accepts plaintext this cycle.
- `ctxt_char`  out  8  ciphertext character.
- `ctxt_valid`  out  1  ciphertext valid.
- `ctxt_last`  out  1  with `ctxt_valid`: this beat is the terminator (`ctxt_char`=0x00).
- `ctxt_ready`  in  1  sink accepts ciphertext.
- `msg_done`  out  1  one-cycle pulse on the cycle the terminator beat handshakes out.
- `err_invalid_ptxt`  out  1  sticky: an out-of-range character was dropped in the current message.
- `char_count`  out  CNT_W  characters encrypted in the current message, saturating.

## Operation
- Constants: P=227, NULL_CHAR=0x00.
- FSM states and transitions:
  - S_NOKEY: no key held. `ptxt_ready`=0.
    - `pk_ready`=1 and `key_err`=0: latch `pk_in`, go to S_IDLE.
  - S_IDLE: key held, between messages.
    - `key_err`=1: clear key, go to S_NOKEY. This has priority over everything else in S_IDLE.
    - `pk_ready`=1: reload key from `pk_in`.
    - First accepted character: clear `char_count` and `err_invalid_ptxt`, go to S_MSG. If that character is the terminator, go straight back to S_IDLE.
  - S_MSG: inside a message. Key is frozen; `pk_ready` and `key_err` are ignored.
    - Accepted terminator: go to S_IDLE.
- Accepted character M, by range:
  - M=0: forward 0x00 unencrypted with `ctxt_last`=1.
  - 1≤M≤226: sum = M+Pk (9 bits, max 452). C = sum≥227 ? sum−227 : sum; one conditional subtract suffices. C=0 is legal data and is distinguished from the terminator only by `ctxt_last`=0. `char_count` increments, saturating at 2^CNT_W−1.
  - M≥227: consumed and dropped (no output beat); `err_invalid_ptxt` is set.
- Pk=0 is legal and gives the identity mapping.

## Timing
- Handshake:
  - `ptxt_ready` = (state≠S_NOKEY) && (!`ctxt_valid` || `ctxt_ready`).
  - Input transfer: `ptxt_valid`&&`ptxt_ready`. Output transfer: `ctxt_valid`&&`ctxt_ready`.
- Latency: a character accepted in cycle N is on `ctxt_char`/`ctxt_valid` in cycle N+1.
- Throughput: 1 char/cycle while `ctxt_ready`=1.
- Output register is held stable while `ctxt_valid`=1 and `ctxt_ready`=0.
- Simultaneous output drain and input accept in one cycle: the output register loads the new beat with no bubble.
- Dropped characters:
  - Produce no beat. If no valid beat is loaded that cycle, `ctxt_valid` falls after the pending beat drains.
  - A dropped character is accepted only when `ptxt_ready`=1, so it still waits on backpressure.
- `msg_done` asserts for exactly one cycle, on the terminator's output transfer cycle.
- `char_count` and `err_invalid_ptxt` update in the cycle after acceptance. They hold after the message ends and until the next message's first accept.
- Key latch in S_NOKEY/S_IDLE: takes effect for characters accepted from the next cycle on.
- Reset values (async, `rst_n` low, also mid-message):
  - state S_NOKEY, key 0, `ctxt_char`=0x00.
  - `ctxt_valid`=0, `ctxt_last`=0, `msg_done`=0, `err_invalid_ptxt`=0, `char_count`=0, `ptxt_ready`=0.
  - A beat in flight is lost.

## Structure
- Shared package `cipher_pkg`:
  - `P`=8'd227, `Q`=8'd225, `NULL_CHAR`=8'h00.
  - `enc_state_t` enum {S_NOKEY, S_IDLE, S_MSG}.
- Sub-module `mod_p_add`: combinational (a+b) mod P on 8-bit operands with a 9-bit intermediate. Reused later by the decrypt stage.

## Test plan
- Sk=10 → Pk=8 driven with `pk_ready`=1; send 'A'(65), 0x00 with `ctxt_ready`=1 → beats 73 (last=0), then 0x00 (last=1); `msg_done` pulses once; `char_count`=1.
- Pk=8; send 220, 219 → 1 and 0 (both last=0); `char_count`=2.
- Pk=8; send 10, 240, 11, 0x00 → beats 18, 19, 0x00/last; `err_invalid_ptxt`=1 from the cycle after 240 is accepted, and cleared on the next message's first char.
- Hold `ctxt_ready`=0 for 5 cycles with a beat pending → `ptxt_ready`=0 and `ctxt_char` stable; release → drains one beat per cycle with no loss or duplication.
- Mid-message `pk_in`=50 with `pk_ready`=1 and `key_err`=1 → ignored, encryption keeps Pk=8. After the terminator with `key_err` still 1 → S_NOKEY, `ptxt_ready`=0.
- Assert `rst_n`=0 with a beat pending mid-message → all outputs at reset values immediately; no key until `pk_ready` asserts again.
